// File: rtl/blk_stream_sink.sv
// Receiver for the 17-bit block-mode stream: checks header/payload/done framing,
// captures payload words and keeps statistics. BLK_STREAM_SINK_THROTTLE_EN adds LFSR ready throttling.
module blk_stream_sink #(
    parameter int          DEPTH     = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     flush,
    input  logic [16:0]              data,
    input  logic                     valid,
    output logic                     ready,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [16:0]              rd_data,
    output logic [15:0]              word_count,
    output logic [15:0]              block_count,
    output logic [31:0]              cycle_count,
    output logic                     done,
    output logic                     overflow,
    output logic                     protocol_err
`ifdef BLK_STREAM_SINK_THROTTLE_EN
    ,
    output logic [31:0]              throttle_cycles
`endif
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);
    localparam logic [16:0] DONE_TOK = 17'h10100;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DONE} state_t;

    function automatic logic [15:0] sat16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction
    function automatic logic [31:0] sat32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d, wc_q, wc_d, bc_q, bc_d;
    logic [31:0] cc_q, cc_d;
    logic [AW:0] wptr_q, wptr_d;
    logic        done_q, done_d, ovf_q, ovf_d, perr_q, perr_d;
    logic        ready_q, ready_d;
    logic        we, xfer, tok, clr;
    logic [16:0] mem [DEPTH];
    logic [16:0] rd_q;

    assign xfer = valid & ready_q & clk_en;
    assign tok  = (data == DONE_TOK);
    assign clr  = ~rst_n | (clk_en & flush);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wptr_d  = wptr_q;
        wc_d    = wc_q;
        bc_d    = bc_q;
        cc_d    = cc_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        perr_d  = perr_q;
        we      = 1'b0;
        if (clk_en) begin
            // The first valid starts the cycle counter even if the word is not taken.
            if (state_q == S_IDLE && valid) begin
                state_d = S_HDR;
                cc_d    = 32'd1;
            end else if (state_q == S_HDR || state_q == S_PAY) begin
                cc_d = sat32(cc_q);
            end
            if (xfer) begin
                if (state_q == S_PAY) begin
                    if (tok) begin
                        perr_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wc_d  = sat16(wc_q);
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = S_HDR;
                        if (wptr_q == PTR_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            we     = 1'b1;
                            wptr_d = wptr_q + 1'b1;
                        end
                    end
                end else if (tok) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    perr_d  = perr_q | data[16];
                    bc_d    = sat16(bc_q);
                    rem_d   = data[15:0];
                    state_d = (data[15:0] == 16'd0) ? S_HDR : S_PAY;
                end
            end
        end
    end

`ifdef BLK_STREAM_SINK_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] thr_q, thr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        thr_d  = thr_q;
        if (clk_en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (valid && !ready_q && state_q != S_DONE) thr_d = sat32(thr_q);
        end
    end
    assign ready_d = clk_en ? ((state_d != S_DONE) & lfsr_d[0]) : ready_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            lfsr_q <= LFSR_SEED;
            thr_q  <= 32'd0;
        end else begin
            lfsr_q <= lfsr_d;
            thr_q  <= thr_d;
        end
    end
    assign throttle_cycles = thr_q;
`else
    assign ready_d = clk_en ? (state_d != S_DONE) : ready_q;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            rem_q   <= 16'd0;
            wptr_q  <= '0;
            wc_q    <= 16'd0;
            bc_q    <= 16'd0;
            cc_q    <= 32'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wptr_q  <= wptr_d;
            wc_q    <= wc_d;
            bc_q    <= bc_d;
            cc_q    <= cc_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            ready_q <= ready_d;
        end
    end

    // Buffer is never cleared; readback keeps running through flush.
    always_ff @(posedge clk) begin
        if (we && !clr) mem[wptr_q[AW-1:0]] <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      rd_q <= 17'd0;
        else if (clk_en) rd_q <= mem[rd_addr];
    end

    assign ready        = ready_q;
    assign rd_data      = rd_q;
    assign word_count   = wc_q;
    assign block_count  = bc_q;
    assign cycle_count  = cc_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign protocol_err = perr_q;
endmodule

// File: tb/tb_blk_stream_sink.sv
// Bench for blk_stream_sink: a 256-deep and a 4-deep instance share one stream,
// checked every cycle against a stream-parsing model plus directed literal expectations.
module tb_blk_stream_sink;
    localparam logic [16:0] TOK = 17'h10100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, clk_en = 1'b1, flush = 1'b0, valid = 1'b0;
    logic [16:0] data = 17'd0;
    logic [7:0]  rd_addr = 8'd0;

    logic        ready_b, done_b, ovf_b, perr_b, ready_s, done_s, ovf_s, perr_s;
    logic [16:0] rd_b, rd_s;
    logic [15:0] wc_b, bc_b, wc_s, bc_s;
    logic [31:0] cc_b, cc_s;
`ifdef BLK_STREAM_SINK_THROTTLE_EN
    logic [31:0] thr_b, thr_s;
`endif

    blk_stream_sink #(.DEPTH(256)) u_big (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .data(data), .valid(valid),
        .ready(ready_b), .rd_addr(rd_addr), .rd_data(rd_b), .word_count(wc_b), .block_count(bc_b),
        .cycle_count(cc_b), .done(done_b), .overflow(ovf_b), .protocol_err(perr_b)
`ifdef BLK_STREAM_SINK_THROTTLE_EN
        , .throttle_cycles(thr_b)
`endif
    );

    blk_stream_sink #(.DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .data(data), .valid(valid),
        .ready(ready_s), .rd_addr(rd_addr[1:0]), .rd_data(rd_s), .word_count(wc_s), .block_count(bc_s),
        .cycle_count(cc_s), .done(done_s), .overflow(ovf_s), .protocol_err(perr_s)
`ifdef BLK_STREAM_SINK_THROTTLE_EN
        , .throttle_cycles(thr_s)
`endif
    );

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_live = 0, m_started, m_done, m_perr, m_ready, m_ovf_b, m_ovf_s;
    int          m_rem, m_nwr;
    logic [15:0] m_wc, m_bc;
    logic [31:0] m_cc, m_thr;
    logic [15:0] m_lfsr;
    logic [16:0] mb_big [256];
    logic [16:0] mb_small [4];
    bit          kb_big [256];
    bit          kb_small [4];
    logic [16:0] m_rd_b, m_rd_s;
    bit          m_rdk_b = 0, m_rdk_s = 0;

    function automatic logic [15:0] s16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction
    function automatic logic [31:0] s32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_clear();
        m_started = 0; m_done = 0; m_perr = 0; m_ready = 1; m_ovf_b = 0; m_ovf_s = 0;
        m_rem = 0; m_nwr = 0; m_wc = 0; m_bc = 0; m_cc = 0; m_thr = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        bit x;
        if (!rst_n) begin
            model_clear();
            m_rd_b = 17'd0; m_rd_s = 17'd0; m_rdk_b = 1; m_rdk_s = 1;
        end else if (clk_en) begin
            m_rd_b = mb_big[rd_addr];        m_rdk_b = kb_big[rd_addr];
            m_rd_s = mb_small[rd_addr[1:0]]; m_rdk_s = kb_small[rd_addr[1:0]];
            if (flush) model_clear();
            else begin
                x = valid && m_ready;
                if (valid && !m_ready && !m_done) m_thr = s32(m_thr);
                if (m_started && !m_done) m_cc = s32(m_cc);
                else if (!m_started && valid) begin m_started = 1; m_cc = 32'd1; end
                if (x) begin
                    if (data == TOK) begin
                        if (m_rem > 0) m_perr = 1;
                        m_done = 1;
                    end else if (m_rem == 0) begin
                        if (data[16]) m_perr = 1;
                        m_bc  = s16(m_bc);
                        m_rem = int'(data[15:0]);
                    end else begin
                        m_wc = s16(m_wc);
                        if (m_nwr < 256) begin mb_big[m_nwr] = data; kb_big[m_nwr] = 1; end
                        else m_ovf_b = 1;
                        if (m_nwr < 4) begin mb_small[m_nwr] = data; kb_small[m_nwr] = 1; end
                        else m_ovf_s = 1;
                        m_nwr++;
                        m_rem--;
                    end
                end
`ifdef BLK_STREAM_SINK_THROTTLE_EN
                m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                m_ready = !m_done && m_lfsr[0];
`else
                m_ready = !m_done;
`endif
            end
        end
        m_live = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) kb_big[i] = 0;
        for (int i = 0; i < 4; i++) kb_small[i] = 0;
        model_clear();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("ready_b", 32'(ready_b), 32'(m_ready));
            chk("ready_s", 32'(ready_s), 32'(m_ready));
            chk("word_count_b", 32'(wc_b), 32'(m_wc));
            chk("word_count_s", 32'(wc_s), 32'(m_wc));
            chk("block_count_b", 32'(bc_b), 32'(m_bc));
            chk("block_count_s", 32'(bc_s), 32'(m_bc));
            chk("cycle_count_b", cc_b, m_cc);
            chk("cycle_count_s", cc_s, m_cc);
            chk("done_b", 32'(done_b), 32'(m_done));
            chk("done_s", 32'(done_s), 32'(m_done));
            chk("overflow_b", 32'(ovf_b), 32'(m_ovf_b));
            chk("overflow_s", 32'(ovf_s), 32'(m_ovf_s));
            chk("protocol_err_b", 32'(perr_b), 32'(m_perr));
            chk("protocol_err_s", 32'(perr_s), 32'(m_perr));
            if (m_rdk_b) chk("rd_data_b", 32'(rd_b), 32'(m_rd_b));
            if (m_rdk_s) chk("rd_data_s", 32'(rd_s), 32'(m_rd_s));
`ifdef BLK_STREAM_SINK_THROTTLE_EN
            chk("throttle_b", thr_b, m_thr);
            chk("throttle_s", thr_s, m_thr);
`endif
        end
    end

    // ---------------- stimulus ----------------
    bit en_rand = 0, addr_rand = 0;

    initial forever begin
        @(posedge clk); #2;
        if (addr_rand) rd_addr = 8'($urandom_range(0, 7));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_en();
        clk_en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic send(input logic [16:0] w);
        int  n = 0;
        bit  got = 0;
        valid = 1'b1; data = w;
        do begin
            @(negedge clk); got = ready_b && clk_en;
            tick(); set_en(); n++;
        end while (!got && n < 500);
        if (!got) begin
            checks++; failures++;
            $display("FAIL send_timeout word=%h waited=%0d cycles", w, n);
        end
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin tick(); set_en(); end
    endtask

    task automatic hold_valid(input int n);
        valid = 1'b1; data = 17'h00055;
        repeat (n) tick();
        valid = 1'b0;
    endtask

    task automatic do_flush();
        valid = 1'b0; flush = 1'b1; clk_en = 1'b1;
        tick(); flush = 1'b0; set_en();
    endtask

    task automatic do_reset();
        valid = 1'b0; rst_n = 1'b0;
        tick(); rst_n = 1'b1; set_en();
    endtask

    task automatic rd_big(input string nm, input logic [7:0] a, input logic [16:0] exp);
        rd_addr = a; tick();
        chk(nm, 32'(rd_b), 32'(exp));
    endtask

    task automatic rd_small(input string nm, input logic [7:0] a, input logic [16:0] exp);
        rd_addr = a; tick();
        chk(nm, 32'(rd_s), 32'(exp));
    endtask

    initial begin
        int nb, len;
        bit trunc;
        logic [16:0] w;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_ready", 32'(ready_b), 32'd1);
        chk("rst_wc", 32'(wc_b), 32'd0);
        chk("rst_done", 32'(done_b), 32'd0);
        chk("rst_rd", 32'(rd_b), 32'd0);

        // single block of three words
        send(17'd3); send(17'h5); send(17'h6); send(17'h7); send(TOK);
        chk("t1_done", 32'(done_b), 32'd1);
        chk("t1_wc", 32'(wc_b), 32'd3);
        chk("t1_bc", 32'(bc_b), 32'd1);
        chk("t1_perr", 32'(perr_b), 32'd0);
`ifndef BLK_STREAM_SINK_THROTTLE_EN
        chk("t1_cc", cc_b, 32'd5);
`endif
        hold_valid(3);
        chk("t1_wc_frozen", 32'(wc_b), 32'd3);
        rd_big("t1_buf0", 8'd0, 17'h5);
        rd_big("t1_buf1", 8'd1, 17'h6);
        rd_big("t1_buf2", 8'd2, 17'h7);

        // three blocks with gaps
        do_flush();
        send(17'd2); send(17'hA); send(17'hB); idle(2);
        send(17'd0); idle(2);
        send(17'd1); send(17'hC); send(TOK);
        chk("t2_bc", 32'(bc_b), 32'd3);
        chk("t2_wc", 32'(wc_b), 32'd3);
        rd_big("t2_buf0", 8'd0, 17'hA);
        rd_big("t2_buf1", 8'd1, 17'hB);
        rd_big("t2_buf2", 8'd2, 17'hC);

        // overflow on the 4-deep instance
        do_flush();
        send(17'd6);
        for (int i = 0; i < 6; i++) send(17'h11 + 17'(i));
        send(TOK);
        chk("t3_ovf_s", 32'(ovf_s), 32'd1);
        chk("t3_ovf_b", 32'(ovf_b), 32'd0);
        chk("t3_wc_s", 32'(wc_s), 32'd6);
        chk("t3_perr_s", 32'(perr_s), 32'd0);
        for (int i = 0; i < 4; i++) rd_small("t3_buf_s", 8'(i), 17'h11 + 17'(i));

        // truncated block
        do_flush();
        send(17'd4); send(17'h1); send(17'h2); send(TOK);
        chk("t4_perr", 32'(perr_b), 32'd1);
        chk("t4_done", 32'(done_b), 32'd1);
        chk("t4_wc", 32'(wc_b), 32'd2);
        chk("t4_ready", 32'(ready_b), 32'd0);
        hold_valid(4);
        chk("t4_wc_frozen", 32'(wc_b), 32'd2);
        chk("t4_ready_held", 32'(ready_b), 32'd0);

        // reset mid-payload
        do_flush();
        send(17'd5); send(17'h21); send(17'h22);
        do_reset();
        chk("t5_wc", 32'(wc_b), 32'd0);
        chk("t5_bc", 32'(bc_b), 32'd0);
        chk("t5_cc", cc_b, 32'd0);
        chk("t5_ready", 32'(ready_b), 32'd1);
        chk("t5_rd", 32'(rd_b), 32'd0);
        send(17'd1); send(17'h9); send(TOK);
        chk("t5_wc_new", 32'(wc_b), 32'd1);
        rd_big("t5_buf0", 8'd0, 17'h9);

`ifdef BLK_STREAM_SINK_THROTTLE_EN
        do_flush();
        send(17'd100);
        for (int i = 0; i < 100; i++) send(17'h100 + 17'(i));
        send(TOK);
        checks++;
        if (thr_b == 32'd0) begin
            failures++;
            $display("FAIL thr_nonzero actual=%0d required=>0", thr_b);
        end
        chk("thr_cc", cc_b, 32'd102 + thr_b);
        rd_big("thr_buf0", 8'd0, 17'h100);
        rd_big("thr_buf99", 8'd99, 17'h100 + 17'd99);
`endif

        // randomized framed streams with random gaps, clock-enable and errors
        en_rand = 1; addr_rand = 1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) do_reset(); else do_flush();
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                len = $urandom_range(0, 5);
                w = 17'(len);
                if ($urandom_range(0, 7) == 0) w[16] = 1'b1;
                send(w);
                trunc = 0;
                for (int j = 0; j < len && !trunc; j++) begin
                    if ($urandom_range(0, 9) == 0) trunc = 1;
                    else begin
                        idle($urandom_range(0, 2));
                        w = 17'($urandom);
                        if (w == TOK) w = 17'h1;
                        send(w);
                    end
                end
                if (trunc) break;
                idle($urandom_range(0, 2));
            end
            send(TOK);
            hold_valid(2);
        end
        en_rand = 0; addr_rand = 0; clk_en = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
